// File: rtl/alu_op_decode.sv
// Decode/issue stage: 32-bit instruction words -> ALU function code, register indices, immediate.
// Optional ALU_OP_DECODE_STATS_EN adds accept_count / illegal_count outputs.

`ifndef FUNC_BITS
`define FUNC_BITS 5
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADD
`define ADD  5'h00
`define SUB  5'h01
`define AND  5'h02
`define OR   5'h03
`define XOR  5'h04
`define NAND 5'h05
`define NOR  5'h06
`define XNOR 5'h07
`define MVHI 5'h08
`define F    5'h10
`define EQ   5'h11
`define LT   5'h12
`define LTE  5'h13
`define T    5'h14
`define NE   5'h15
`define GTE  5'h16
`define GT   5'h17
`endif

module alu_op_decode #(
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned WORD_SIZE = `WORD_SIZE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [31:0]           in_inst,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [`FUNC_BITS-1:0] out_func,
   output logic [3:0]            out_rd,
   output logic [3:0]            out_rs1,
   output logic [3:0]            out_rs2,
   output logic [WORD_SIZE-1:0]  out_imm,
   output logic                  out_use_imm,
   output logic                  illegal,
   output logic                  illegal_seen
`ifdef ALU_OP_DECODE_STATS_EN
   ,
   output logic [31:0]           accept_count,
   output logic [15:0]           illegal_count
`endif
);

   localparam int unsigned CNT_W = 2;

   typedef struct packed {
      logic [`FUNC_BITS-1:0] func;
      logic [3:0]            rd;
      logic [3:0]            rs1;
      logic [3:0]            rs2;
      logic [WORD_SIZE-1:0]  imm;
      logic                  use_imm;
   } entry_t;

   entry_t           head_q, tail_q, dec;
   logic [CNT_W-1:0] count_q, count_nxt;
   logic             dec_legal, is_mvhi;
   logic             accept, push, pop;
   logic [3:0]       op, fn;

   assign op = in_inst[31:28];
   assign fn = in_inst[27:24];

   // Combinational decode of the instruction presented at the input.
   always_comb begin
      dec_legal   = 1'b0;
      is_mvhi     = 1'b0;
      dec.func    = '0;
      dec.use_imm = (op == 4'h4) || (op == 4'h5);
      dec.rd      = in_inst[23:20];
      dec.rs1     = in_inst[19:16];
      dec.rs2     = in_inst[15:12];
      case (op)
         4'hC, 4'h4: begin
            dec_legal = 1'b1;
            case (fn)
               4'h0: dec.func = `ADD;
               4'h1: dec.func = `SUB;
               4'h2: dec.func = `AND;
               4'h3: dec.func = `OR;
               4'h4: dec.func = `XOR;
               4'h5: dec.func = `NAND;
               4'h6: dec.func = `NOR;
               4'h7: dec.func = `XNOR;
               4'h8: begin dec.func = `MVHI; is_mvhi = 1'b1; end
               default: dec_legal = 1'b0;
            endcase
         end
         4'hD, 4'h5: begin
            dec_legal = 1'b1;
            case (fn)
               4'h0: dec.func = `F;
               4'h1: dec.func = `EQ;
               4'h2: dec.func = `LT;
               4'h3: dec.func = `LTE;
               4'h4: dec.func = `T;
               4'h5: dec.func = `NE;
               4'h6: dec.func = `GTE;
               4'h7: dec.func = `GT;
               default: dec_legal = 1'b0;
            endcase
         end
         default: dec_legal = 1'b0;
      endcase
      // MVHI takes its immediate unsigned; everything else sign-extends.
      dec.imm = is_mvhi ? {{(WORD_SIZE-16){1'b0}}, in_inst[15:0]}
                        : {{(WORD_SIZE-16){in_inst[15]}}, in_inst[15:0]};
   end

   assign accept    = in_valid && in_ready;
   assign push      = accept && dec_legal;
   assign pop       = out_valid && out_ready;
   assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);

   // Two-entry FIFO: head_q always drives the outputs, tail_q holds the second entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q      <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         illegal      <= 1'b0;
         illegal_seen <= 1'b0;
      end else begin
         count_q   <= count_nxt;
         in_ready  <= (count_nxt != CNT_W'(DEPTH));
         out_valid <= (count_nxt != '0);
         illegal   <= accept && !dec_legal;
         if (accept && !dec_legal)
            illegal_seen <= 1'b1;

         if (pop && (count_q == 2'd2))
            head_q <= tail_q;
         else if (push && ((count_q == 2'd0) || (count_q == 2'd1 && pop)))
            head_q <= dec;

         if (push && (count_q == 2'd1) && !pop)
            tail_q <= dec;
      end
   end

   assign out_func    = head_q.func;
   assign out_rd      = head_q.rd;
   assign out_rs1     = head_q.rs1;
   assign out_rs2     = head_q.rs2;
   assign out_imm     = head_q.imm;
   assign out_use_imm = head_q.use_imm;

`ifdef ALU_OP_DECODE_STATS_EN
   // Legal-push counter wraps; illegal counter saturates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         accept_count  <= '0;
         illegal_count <= '0;
      end else begin
         if (push)
            accept_count <= accept_count + 32'd1;
         if (accept && !dec_legal && (illegal_count != 16'hFFFF))
            illegal_count <= illegal_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_op_decode.sv
// Table-driven bench for alu_op_decode plus directed stall, illegal and reset sequences.

`ifndef FUNC_BITS
`define FUNC_BITS 5
`endif
`ifndef ADD
`define ADD  5'h00
`define SUB  5'h01
`define AND  5'h02
`define OR   5'h03
`define XOR  5'h04
`define NAND 5'h05
`define NOR  5'h06
`define XNOR 5'h07
`define MVHI 5'h08
`define F    5'h10
`define EQ   5'h11
`define LT   5'h12
`define LTE  5'h13
`define T    5'h14
`define NE   5'h15
`define GTE  5'h16
`define GT   5'h17
`endif

module tb_alu_op_decode;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  in_valid = 1'b0;
   logic [31:0]           in_inst = '0;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic [`FUNC_BITS-1:0] out_func;
   logic [3:0]            out_rd, out_rs1, out_rs2;
   logic [31:0]           out_imm;
   logic                  out_use_imm;
   logic                  illegal;
   logic                  illegal_seen;
`ifdef ALU_OP_DECODE_STATS_EN
   logic [31:0]           accept_count;
   logic [15:0]           illegal_count;
`endif

   int checks = 0;
   int failures = 0;

   alu_op_decode dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_func(out_func), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_imm(out_imm), .out_use_imm(out_use_imm),
      .illegal(illegal), .illegal_seen(illegal_seen)
`ifdef ALU_OP_DECODE_STATS_EN
      , .accept_count(accept_count), .illegal_count(illegal_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]           inst;
      logic                  legal;
      logic [`FUNC_BITS-1:0] func;
      logic [3:0]            rd, rs1, rs2;
      logic [31:0]           imm;
      logic                  use_imm;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string name, input logic [`FUNC_BITS-1:0] f, input logic [3:0] rd);
      check({name, ".valid"}, 32'(out_valid), 32'd1);
      check({name, ".func"}, 32'(out_func), 32'(f));
      check({name, ".rd"}, 32'(out_rd), 32'(rd));
   endtask

   initial begin
      vecs[0]  = '{32'hC1312000, 1'b1, `SUB,  4'h3, 4'h1, 4'h2, 32'h00002000, 1'b0};
      vecs[1]  = '{32'h4050FFFF, 1'b1, `ADD,  4'h5, 4'h0, 4'hF, 32'hFFFFFFFF, 1'b1};
      vecs[2]  = '{32'h48501234, 1'b1, `MVHI, 4'h5, 4'h0, 4'h1, 32'h00001234, 1'b1};
      vecs[3]  = '{32'h52208000, 1'b1, `LT,   4'h2, 4'h0, 4'h8, 32'hFFFF8000, 1'b1};
      vecs[4]  = '{32'hD7ABC000, 1'b1, `GT,   4'hA, 4'hB, 4'hC, 32'hFFFFC000, 1'b0};
      vecs[5]  = '{32'h48008000, 1'b1, `MVHI, 4'h0, 4'h0, 4'h8, 32'h00008000, 1'b1};
      vecs[6]  = '{32'hC0008000, 1'b1, `ADD,  4'h0, 4'h0, 4'h8, 32'hFFFF8000, 1'b0};
      vecs[7]  = '{32'h57917FFF, 1'b1, `GT,   4'h9, 4'h1, 4'h7, 32'h00007FFF, 1'b1};
      vecs[8]  = '{32'h58000000, 1'b0, '0,    4'h0, 4'h0, 4'h0, 32'h0,         1'b0};
      vecs[9]  = '{32'h00000000, 1'b0, '0,    4'h0, 4'h0, 4'h0, 32'h0,         1'b0};
      vecs[10] = '{32'hC7654000, 1'b1, `XNOR, 4'h6, 4'h5, 4'h4, 32'h00004000, 1'b0};

      // Reset state
      #2;
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.illegal_seen", 32'(illegal_seen), 32'd0);
      check("rst.func", 32'(out_func), 32'd0);
      check("rst.imm", out_imm, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("rst.in_ready", 32'(in_ready), 32'd1);

      // Single-op table, out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         in_valid = 1'b1;
         in_inst  = vecs[i].inst;
         tick();
         in_valid = 1'b0;
         check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].legal));
         check($sformatf("v%0d.illegal", i), 32'(illegal), 32'(!vecs[i].legal));
         if (vecs[i].legal) begin
            check($sformatf("v%0d.func", i), 32'(out_func), 32'(vecs[i].func));
            check($sformatf("v%0d.rd", i), 32'(out_rd), 32'(vecs[i].rd));
            check($sformatf("v%0d.rs1", i), 32'(out_rs1), 32'(vecs[i].rs1));
            check($sformatf("v%0d.rs2", i), 32'(out_rs2), 32'(vecs[i].rs2));
            check($sformatf("v%0d.imm", i), out_imm, vecs[i].imm);
            check($sformatf("v%0d.use_imm", i), 32'(out_use_imm), 32'(vecs[i].use_imm));
         end
         tick();
         check($sformatf("v%0d.drained", i), 32'(out_valid), 32'd0);
         check($sformatf("v%0d.illegal_off", i), 32'(illegal), 32'd0);
      end
      check("table.illegal_seen", 32'(illegal_seen), 32'd1);

      // Back-to-back throughput with out_ready=1
      in_valid = 1'b1;
      in_inst  = 32'hC3100000;
      tick();
      in_inst  = 32'hC4200000;
      check_head("tp0", `OR, 4'h1);
      tick();
      in_valid = 1'b0;
      check_head("tp1", `XOR, 4'h2);
      check("tp1.in_ready", 32'(in_ready), 32'd1);
      tick();
      check("tp.drained", 32'(out_valid), 32'd0);

      // Fresh reset so illegal_seen starts clear for the stall/illegal sequences
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      // Stall: fill to 2, third op waits; release drains in order
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'hC1312000;
      tick();
      in_inst   = 32'hC2456000;
      tick();
      check("stall.in_ready", 32'(in_ready), 32'd0);
      check_head("stall.a", `SUB, 4'h3);
      in_inst   = 32'hD1789000;
      tick();
      check("stall2.in_ready", 32'(in_ready), 32'd0);
      check_head("stall2.a", `SUB, 4'h3);
      check("stall2.imm", out_imm, 32'h00002000);
      out_ready = 1'b1;
      tick();
      check("rel.in_ready", 32'(in_ready), 32'd1);
      check_head("rel.b", `AND, 4'h4);
      tick();
      in_valid  = 1'b0;
      check_head("rel.c", `EQ, 4'h7);
      check("rel.c.imm", out_imm, 32'hFFFF9000);
      tick();
      check("rel.drained", 32'(out_valid), 32'd0);
      check("rel.illegal_seen", 32'(illegal_seen), 32'd0);

      // Back-to-back illegal instructions
      in_valid = 1'b1;
      in_inst  = 32'hF0000000;
      tick();
      check("ill0.illegal", 32'(illegal), 32'd1);
      check("ill0.out_valid", 32'(out_valid), 32'd0);
      in_inst  = 32'hC9000000;
      tick();
      in_valid = 1'b0;
      check("ill1.illegal", 32'(illegal), 32'd1);
      check("ill1.out_valid", 32'(out_valid), 32'd0);
      tick();
      check("ill2.illegal", 32'(illegal), 32'd0);
      check("ill2.illegal_seen", 32'(illegal_seen), 32'd1);
`ifdef ALU_OP_DECODE_STATS_EN
      check("stats.accept_count", accept_count, 32'd3);
      check("stats.illegal_count", 32'(illegal_count), 32'd2);
`endif

      // Reset mid-stream with the buffer full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h4050FFFF;
      tick();
      tick();
      in_valid  = 1'b0;
      check("mid.in_ready", 32'(in_ready), 32'd0);
      reset = 1'b1;
      #1;
      check("mid.out_valid", 32'(out_valid), 32'd0);
      check("mid.imm", out_imm, 32'd0);
      check("mid.use_imm", 32'(out_use_imm), 32'd0);
      check("mid.illegal_seen", 32'(illegal_seen), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("post.in_ready", 32'(in_ready), 32'd1);
      check("post.out_valid", 32'(out_valid), 32'd0);
`ifdef ALU_OP_DECODE_STATS_EN
      check("post.accept_count", accept_count, 32'd0);
      check("post.illegal_count", 32'(illegal_count), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
